input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Sits directly upstream of the on-board I/O register block: takes raw Basys3 switch and button pins and produces clean, debounced levels for the sw/btn inputs of that block.
- Also produces one-clock press, release and auto-repeat event pulses per button, for software polling or interrupt logic.
- Replaces the coarse free-running-sample debounce with a synchronized, counter-qualified scheme.

Parameters:
- N_SW, 16, number of switch channels.
- N_BTN, 5, number of button channels; bit order btnC, btnU, btnL, btnR, btnD (bit 0 = btnC).
- TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); must be >= 2.
- STABLE_TICKS, 20, consecutive ticks a changed input must hold before the clean level updates; must be >= 1.
- REPEAT_DELAY, 500, ticks a button must be held before the first repeat pulse; must be >= 1.
- REPEAT_RATE, 100, ticks between subsequent repeat pulses; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_raw  in  N_SW  raw switch pins.
- btn_raw  in  N_BTN  raw button pins, active high.
- sw  out  N_SW  debounced switch levels.
- btn  out  N_BTN  debounced button levels.
- btn_press  out  N_BTN  one-clk pulse on a clean 0->1 transition.
- btn_release  out  N_BTN  one-clk pulse on a clean 1->0 transition.
- btn_repeat  out  N_BTN  one-clk pulse per auto-repeat interval while held.
- event_any  out  1  OR of all btn_press and btn_repeat bits.

Behaviour:
- Reset (rst_n low, asynchronous): synchronizers, clean levels, all counters, tick divider and repeat FSMs go to 0/IDLE; all outputs 0. On release, operation resumes from the all-zero state.
- Synchronizer:
  - Every raw input passes through a 2-flop synchronizer; the result is sync[i].
  - The raw-to-sync delay is 2 clk.
- Tick generator:
  - A divider counts 0..TICK_DIV-1 and wraps.
  - tick is a one-clk internal pulse asserted on the wrap cycle.
  - The first tick occurs TICK_DIV clk after reset release.
- Debounce (each channel independently, switches and buttons alike):
  - Stability counter width is clog2(STABLE_TICKS+1).
  - On a tick cycle where sync differs from the clean level: count increments.
  - When the incremented value equals STABLE_TICKS, the clean level takes the sync value on that clk edge and count clears.
  - On a tick cycle where sync equals the clean level: count clears.
  - Counting happens only on tick cycles; between ticks the count holds.
  - A glitch shorter than STABLE_TICKS ticks never changes the clean level.
- Button events:
  - All event pulses are registered and assert in the same clk cycle as the clean-level change.
  - btn_press[i] = clean rose; btn_release[i] = clean fell; each is high for exactly 1 clk.
- Repeat FSM, per button, states IDLE, HOLD, REPEAT, with a repeat counter sized for max(REPEAT_DELAY, REPEAT_RATE):
  - IDLE: on press, go to HOLD with cnt=0.
  - HOLD: on each tick, cnt++. When cnt reaches REPEAT_DELAY, pulse btn_repeat, set cnt=0, go to REPEAT.
  - REPEAT: on each tick, cnt++. When cnt reaches REPEAT_RATE, pulse btn_repeat and set cnt=0.
  - Any state: on release, go to IDLE with cnt=0.
- Simultaneous events:
  - Release and a repeat-qualifying tick in the same cycle: release wins, no repeat pulse.
  - Press and repeat can never coincide, because the press cycle enters HOLD with cnt=0.
- event_any is combinational, from the registered pulses.
- Switches produce no events.

Test Plan:
Use TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2 for all scenarios.
- Reset: hold rst_n=0 with sw_raw=16'hFFFF -> all outputs 0. After release, sw=16'hFFFF after 2 clk sync plus 3 ticks, i.e. the 3rd tick (clk 12); never earlier.
- Glitch rejection: btn_raw[0] high for 2 ticks, then low -> btn stays 0, and no btn_press, btn_release or event_any pulse.
- Clean press/release: btn_raw[1] held high for 6 ticks, then low -> btn_press[1] for exactly 1 clk at the 3rd tick; btn_release[1] for 1 clk at the 3rd tick after the drop.
- Auto-repeat: hold btn_raw[2] for 20 ticks -> press at tick 3; repeats at ticks 8, 10, 12, 14, ... (the first 5 ticks after press, then every 2); event_any mirrors each pulse.
- Release/repeat collision: release qualifies on the same tick a repeat would fire -> btn_release pulse only, FSM returns to IDLE, btn_repeat stays 0.
- Async reset mid-hold: assert rst_n low during REPEAT, off a clk edge -> outputs clear immediately. With the button still held after release, a new press occurs 3 ticks later and repeat timing restarts from HOLD.

Source files
------------

// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes raw Basys3 switch/button pins, debounces them
// on a divided sample tick, and generates per-button press/release/auto-repeat
// event pulses for the I/O register block and its polling/interrupt logic.
module input_conditioner #(
  parameter int unsigned N_SW         = 16,
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  sw,
  output logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             event_any
);

  localparam int unsigned N_CH    = N_SW + N_BTN;
  localparam int unsigned DIV_W   = $clog2(TICK_DIV);
  localparam int unsigned STB_W   = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_TICKS);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Channel vector: switches in the low bits, buttons above them.
  logic [N_CH-1:0]  sync_q1;
  logic [N_CH-1:0]  sync_q2;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [N_CH-1:0]  clean_q;
  logic [N_CH-1:0]  clean_d;
  logic [STB_W-1:0] stb_q [N_CH];
  logic [STB_W-1:0] stb_d [N_CH];
  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] release_c;
  logic [N_BTN-1:0] repeat_c;
  rpt_state_t       rpt_state_q [N_BTN];
  rpt_state_t       rpt_state_d [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_q   [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_d   [N_BTN];

  // Two-flop synchronizer for every raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {btn_raw, sw_raw};
      sync_q2 <= sync_q1;
    end
  end

  // Sample-tick divider; tick marks the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

  // Debounce next state: a level change must persist STABLE_TICKS ticks.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < N_CH; i++) begin
      stb_d[i] = stb_q[i];
      if (tick) begin
        if (sync_q2[i] != clean_q[i]) begin
          if ((stb_q[i] + STB_W'(1)) == STB_LAST) begin
            clean_d[i] = sync_q2[i];
            stb_d[i]   = '0;
          end else begin
            stb_d[i] = stb_q[i] + STB_W'(1);
          end
        end else begin
          stb_d[i] = '0;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stb_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < N_CH; i++) begin
        stb_q[i] <= stb_d[i];
      end
    end
  end

  // Clean-level edges, seen in the same cycle the clean level updates.
  assign press_c   =  clean_d[N_CH-1:N_SW] & ~clean_q[N_CH-1:N_SW];
  assign release_c = ~clean_d[N_CH-1:N_SW] &  clean_q[N_CH-1:N_SW];

  // Repeat FSM next state; release overrides any repeat on the same cycle.
  always_comb begin
    repeat_c = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      if (release_c[i]) begin
        rpt_state_d[i] = IDLE;
        rpt_cnt_d[i]   = '0;
      end else begin
        case (rpt_state_q[i])
          IDLE: begin
            if (press_c[i]) begin
              rpt_state_d[i] = HOLD;
              rpt_cnt_d[i]   = '0;
            end
          end
          HOLD: begin
            if (tick) begin
              if ((rpt_cnt_q[i] + RPT_W'(1)) == RPT_DELAY) begin
                repeat_c[i]    = 1'b1;
                rpt_cnt_d[i]   = '0;
                rpt_state_d[i] = REPEAT;
              end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if ((rpt_cnt_q[i] + RPT_W'(1)) == RPT_RATE) begin
                repeat_c[i]  = 1'b1;
                rpt_cnt_d[i] = '0;
              end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
              end
            end
          end
          default: begin
            rpt_state_d[i] = IDLE;
            rpt_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= IDLE;
        rpt_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
    end
  end

  // Registered event pulses, aligned with the clean-level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
    end else begin
      btn_press   <= press_c;
      btn_release <= release_c;
      btn_repeat  <= repeat_c;
    end
  end

  assign sw        = clean_q[N_SW-1:0];
  assign btn       = clean_q[N_CH-1:N_SW];
  assign event_any = |(btn_press | btn_repeat);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2. Edge numbers count posedges since reset release;
// ticks land on every 4th edge.
module tb_input_conditioner;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw_raw;
  logic [4:0]  btn_raw;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [4:0]  btn_press;
  logic [4:0]  btn_release;
  logic [4:0]  btn_repeat;
  logic        event_any;

  int checks;
  int errors;
  int ecnt;

  input_conditioner #(
    .N_SW(16), .N_BTN(5), .TICK_DIV(4), .STABLE_TICKS(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sw(sw), .btn(btn), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .event_any(event_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] sw_raw;
    logic [4:0]  btn_raw;
    int          ncyc;
    logic [15:0] e_sw;
    logic [4:0]  e_btn;
    logic [4:0]  e_press;
    logic [4:0]  e_rel;
    logic [4:0]  e_rep;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Expected output word; event_any is the OR of press and repeat bits.
  function automatic logic [36:0] pk(input logic [15:0] s, input logic [4:0] b,
                                     input logic [4:0] p, input logic [4:0] r,
                                     input logic [4:0] rp);
    return {s, b, p, r, rp, |(p | rp)};
  endfunction

  task automatic check(input string name, input logic [36:0] exp);
    logic [36:0] act;
    act = {sw, btn, btn_press, btn_release, btn_repeat, event_any};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %h expected %h", name, ecnt, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ecnt++;
  endtask

  initial begin
    logic [4:0] ep, er, erp, eb;
    logic [15:0] es;

    checks = 0;
    errors = 0;
    ecnt   = 0;

    // inputs, cycles, expected sw/btn/press/release/repeat held for every cycle
    vecs[0]  = '{16'hFFFF, 5'h00, 11, 16'h0000, 5'h00, 5'h00, 5'h00, 5'h00}; // e1..11
    vecs[1]  = '{16'hFFFF, 5'h00,  1, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00}; // e12
    vecs[2]  = '{16'hFFFF, 5'h01,  8, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00}; // glitch
    vecs[3]  = '{16'hFFFF, 5'h00,  8, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[4]  = '{16'hFFFF, 5'h02, 11, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00}; // e29..39
    vecs[5]  = '{16'hFFFF, 5'h02,  1, 16'hFFFF, 5'h02, 5'h02, 5'h00, 5'h00}; // press e40
    vecs[6]  = '{16'hFFFF, 5'h02, 12, 16'hFFFF, 5'h02, 5'h00, 5'h00, 5'h00}; // e41..52
    vecs[7]  = '{16'hFFFF, 5'h00,  7, 16'hFFFF, 5'h02, 5'h00, 5'h00, 5'h00}; // e53..59
    vecs[8]  = '{16'hFFFF, 5'h00,  1, 16'hFFFF, 5'h02, 5'h00, 5'h00, 5'h02}; // repeat e60
    vecs[9]  = '{16'hFFFF, 5'h00,  3, 16'hFFFF, 5'h02, 5'h00, 5'h00, 5'h00};
    vecs[10] = '{16'hFFFF, 5'h00,  1, 16'hFFFF, 5'h00, 5'h00, 5'h02, 5'h00}; // release e64
    vecs[11] = '{16'hFFFF, 5'h00,  4, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[12] = '{16'hA5A5, 5'h00, 11, 16'hFFFF, 5'h00, 5'h00, 5'h00, 5'h00}; // e69..79
    vecs[13] = '{16'hA5A5, 5'h00,  1, 16'hA5A5, 5'h00, 5'h00, 5'h00, 5'h00}; // e80

    // Reset held with switches high: everything stays zero.
    rst_n   = 1'b0;
    sw_raw  = 16'hFFFF;
    btn_raw = 5'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_hold", pk(16'h0, 5'h0, 5'h0, 5'h0, 5'h0));
    end
    rst_n = 1'b1;
    ecnt  = 0;

    // Table: reset release, glitch, clean press/release, switch change.
    for (int v = 0; v < NV; v++) begin
      sw_raw  = vecs[v].sw_raw;
      btn_raw = vecs[v].btn_raw;
      for (int k = 0; k < vecs[v].ncyc; k++) begin
        step();
        check($sformatf("vec%0d", v),
              pk(vecs[v].e_sw, vecs[v].e_btn, vecs[v].e_press, vecs[v].e_rel, vecs[v].e_rep));
      end
    end

    // Auto-repeat on btn[2], released so the release lands on a repeat tick.
    for (int e = 81; e <= 176; e++) begin
      btn_raw = (e <= 156) ? 5'h04 : 5'h00;
      step();
      eb  = (e >= 92 && e < 168) ? 5'h04 : 5'h00;
      ep  = (e == 92) ? 5'h04 : 5'h00;
      er  = (e == 168) ? 5'h04 : 5'h00;
      erp = (e == 112 || e == 120 || e == 128 || e == 136 ||
             e == 144 || e == 152 || e == 160) ? 5'h04 : 5'h00;
      check("autorepeat", pk(16'hA5A5, eb, ep, er, erp));
    end

    // Hold btn[4] into the REPEAT state.
    btn_raw = 5'h10;
    for (int e = 177; e <= 212; e++) begin
      step();
      eb  = (e >= 188) ? 5'h10 : 5'h00;
      ep  = (e == 188) ? 5'h10 : 5'h00;
      erp = (e == 208) ? 5'h10 : 5'h00;
      check("hold_btn4", pk(16'hA5A5, eb, ep, 5'h00, erp));
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check("async_rst", pk(16'h0, 5'h0, 5'h0, 5'h0, 5'h0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("async_rst_hold", pk(16'h0, 5'h0, 5'h0, 5'h0, 5'h0));
    end
    rst_n = 1'b1;
    ecnt  = 0;

    // Button still held: fresh press at tick 3, repeat timing restarts from HOLD.
    for (int e = 1; e <= 44; e++) begin
      step();
      es  = (e >= 12) ? 16'hA5A5 : 16'h0000;
      eb  = (e >= 12) ? 5'h10 : 5'h00;
      ep  = (e == 12) ? 5'h10 : 5'h00;
      erp = (e == 32 || e == 40) ? 5'h10 : 5'h00;
      check("post_rst", pk(es, eb, ep, 5'h00, erp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
